// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush arbiter with data-bus wait FSM
// Optional stall/flush performance counters are enabled by PIPE_STALL_PERF_EN.
module pipe_stall_ctrl #(
    parameter int          BUS_TIMEOUT = 16,
    parameter int          CNT_W       = 5,
    parameter logic [31:0] ERR_VEC     = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_lduse_req_i,
    input  logic        ex_branch_flag_i,
    input  logic [31:0] ex_branch_addr_i,
    input  logic        mem_req_valid_i,
    input  logic        mem_req_ready_i,
    output logic [2:0]  stalled,
    output logic        flush_o,
    output logic [31:0] flush_addr_o,
    output logic        bus_wait_o,
    output logic        bus_err_o,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUS_WAIT = 2'd1,
        S_BUS_ERR  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       stall_d;
    logic             flush_d;
    logic [31:0]      addr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_d = 3'b000;
        flush_d = 1'b0;
        addr_d  = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (mem_req_valid_i && !mem_req_ready_i) begin
                    stall_d = 3'b110;
                    state_d = S_BUS_WAIT;
                    cnt_d   = CNT_W'(1);
                end else if (ex_branch_flag_i) begin
                    flush_d = 1'b1;
                    addr_d  = ex_branch_addr_i;
                end else if (id_lduse_req_i) begin
                    stall_d = 3'b011;
                end
            end
            S_BUS_WAIT: begin
                // A dropped request is an abort and releases the pipe like a completion.
                if (!mem_req_valid_i || mem_req_ready_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    stall_d = 3'b110;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_BUS_ERR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_BUS_ERR: begin
                stall_d = 3'b001;
                flush_d = 1'b1;
                addr_d  = ERR_VEC;
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bus_err_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_o <= (state_d == S_BUS_ERR);
        end
    end

    assign stalled      = rst ? 3'b000 : stall_d;
    assign flush_o      = rst ? 1'b0 : flush_d;
    assign flush_addr_o = rst ? 32'h0 : addr_d;
    assign bus_wait_o   = (state_q == S_BUS_WAIT);

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            if (stalled != 3'b000) perf_stall_q <= perf_stall_q + 32'h1;
            if (flush_o)           perf_flush_q <= perf_flush_q + 32'h1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`else
    assign perf_stall_cnt_o = 32'h0;
    assign perf_flush_cnt_o = 32'h0;
`endif

endmodule
